// File: rtl/recip_freq_meter.sv
// Reciprocal frequency meter: counts clk cycles and signal periods
// between edge-aligned gate open/close, with timeout and saturation flags.
`timescale 1ns/1ps
module recip_freq_meter #(
    parameter int CNT_W          = 32,
    parameter int GATE_W         = 32,
    parameter int TIMEOUT_CYCLES = 200_000_000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wave,
    input  logic              start,
    input  logic              continuous,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_cycles,
    output logic              busy,
    output logic              result_valid,
    output logic [CNT_W-1:0]  ref_count,
    output logic [CNT_W-1:0]  sig_count,
    output logic              timeout,
    output logic              overflow
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam int CMP_W = (CNT_W > GATE_W) ? CNT_W : GATE_W;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

    state_t state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic hist;
    logic sig_edge;
    logic [CNT_W-1:0] ref_cnt, ref_cnt_n, sig_cnt, sig_cnt_n;
    logic [CNT_W-1:0] ref_inc, sig_inc;
    logic [CNT_W-1:0] ref_count_n, sig_count_n;
    logic [GATE_W-1:0] gate_lat, gate_lat_n, gate_eff;
    logic [WD_W-1:0] wd, wd_n;
    logic ovf, ovf_n, sat, closing, expired;
    logic rv_n, timeout_n, overflow_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], wave};
            hist <= sync[SYNC_STAGES-1];
        end
    end

    assign sig_edge = sync[SYNC_STAGES-1] & ~hist;
    assign busy = (state != IDLE);

    always_comb begin
        ref_inc  = (&ref_cnt) ? ref_cnt : ref_cnt + CNT_W'(1);
        sig_inc  = sig_cnt;
        if (sig_edge && !(&sig_cnt))
            sig_inc = sig_cnt + CNT_W'(1);
        sat      = (&ref_inc) | (&sig_inc);
        // a saturated ref counter can never reach a larger gate, so it closes too
        closing  = sig_edge &&
                   ((CMP_W'(ref_inc) >= CMP_W'(gate_lat)) || (&ref_inc));
        expired  = (wd == WD_LAST);
        gate_eff = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
    end

    always_comb begin
        state_n     = state;
        ref_cnt_n   = ref_cnt;
        sig_cnt_n   = sig_cnt;
        ovf_n       = ovf;
        gate_lat_n  = gate_lat;
        wd_n        = wd;
        rv_n        = 1'b0;
        ref_count_n = ref_count;
        sig_count_n = sig_count;
        timeout_n   = timeout;
        overflow_n  = overflow;
        unique case (state)
            IDLE: begin
                if (start) begin
                    gate_lat_n = gate_eff;
                    wd_n       = '0;
                    state_n    = ARM;
                end
            end
            ARM: begin
                wd_n = wd + WD_W'(1);
                if (expired) begin
                    rv_n        = 1'b1;
                    ref_count_n = '0;
                    sig_count_n = '0;
                    timeout_n   = 1'b1;
                    overflow_n  = 1'b0;
                    state_n     = IDLE;
                end else if (sig_edge) begin
                    ref_cnt_n = '0;
                    sig_cnt_n = '0;
                    ovf_n     = 1'b0;
                    state_n   = MEAS;
                end
            end
            MEAS: begin
                wd_n      = wd + WD_W'(1);
                ref_cnt_n = ref_inc;
                sig_cnt_n = sig_inc;
                ovf_n     = ovf | sat;
                if (closing) begin
                    rv_n        = 1'b1;
                    ref_count_n = ref_inc;
                    sig_count_n = sig_inc;
                    timeout_n   = 1'b0;
                    overflow_n  = ovf | sat;
                    wd_n        = '0;
                    if (continuous) begin
                        ref_cnt_n  = '0;
                        sig_cnt_n  = '0;
                        ovf_n      = 1'b0;
                        gate_lat_n = gate_eff;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (expired) begin
                    rv_n        = 1'b1;
                    ref_count_n = '0;
                    sig_count_n = '0;
                    timeout_n   = 1'b1;
                    overflow_n  = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // abort discards everything, including a publish in the same cycle
        if (abort) begin
            state_n     = IDLE;
            rv_n        = 1'b0;
            ref_count_n = ref_count;
            sig_count_n = sig_count;
            timeout_n   = timeout;
            overflow_n  = overflow;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ref_cnt      <= '0;
            sig_cnt      <= '0;
            ovf          <= 1'b0;
            gate_lat     <= '0;
            wd           <= '0;
            result_valid <= 1'b0;
            ref_count    <= '0;
            sig_count    <= '0;
            timeout      <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state        <= state_n;
            ref_cnt      <= ref_cnt_n;
            sig_cnt      <= sig_cnt_n;
            ovf          <= ovf_n;
            gate_lat     <= gate_lat_n;
            wd           <= wd_n;
            result_valid <= rv_n;
            ref_count    <= ref_count_n;
            sig_count    <= sig_count_n;
            timeout      <= timeout_n;
            overflow     <= overflow_n;
        end
    end
endmodule

// File: tb/tb_recip_freq_meter.sv
// Self-checking bench for recip_freq_meter: vector table, random
// measurements against an arithmetic model, and multi-cycle corner cases.
`timescale 1ns/1ps
module tb_recip_freq_meter;
    localparam int CNT_W = 8;
    localparam int GATE_W = 32;
    localparam int TMO = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wave = 1'b0;
    logic start = 1'b0;
    logic continuous = 1'b0;
    logic abort = 1'b0;
    logic [GATE_W-1:0] gate_cycles = '0;
    logic busy, result_valid, timeout, overflow;
    logic [CNT_W-1:0] ref_count, sig_count;

    recip_freq_meter #(
        .CNT_W(CNT_W), .GATE_W(GATE_W),
        .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .wave(wave), .start(start),
        .continuous(continuous), .abort(abort),
        .gate_cycles(gate_cycles), .busy(busy),
        .result_valid(result_valid), .ref_count(ref_count),
        .sig_count(sig_count), .timeout(timeout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int s;
        bit t;
        bit o;
        int c;
    } res_t;

    typedef struct {
        int per;
        int gate;
        int ref_e;
        int sig_e;
        bit ovf_e;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int per_v = 10;
    bit wave_on = 1'b0;
    res_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (result_valid)
            q.push_back('{int'(ref_count), int'(sig_count), timeout, overflow, cyc});

    // wave generator: rising edge every per_v clk cycles, offset from clk edge
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!wave_on) begin
                wave = 1'b0;
                ph = 0;
            end else begin
                wave = (ph < per_v / 2);
                ph = (ph + 1) % per_v;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_res(input int budget, output res_t r, output bit got);
        got = 1'b0;
        r = '{0, 0, 1'b0, 1'b0, 0};
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                r = q.pop_front();
                got = 1'b1;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL wait_result: no result_valid within %0d cycles", budget);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    function automatic void model(input int per, input int gate,
                                  output int r, output int s, output bit o);
        int g, n, full;
        full = (1 << CNT_W) - 1;
        g = (gate == 0) ? 1 : gate;
        if (g > full) g = full;
        n = (g + per - 1) / per;
        r = n * per;
        o = (r >= full) || (n >= full);
        if (r > full) r = full;
        s = n;
    endfunction

    task automatic run_meas(input string name, input int per, input int gate,
                            input int er, input int es, input bit eo);
        res_t r;
        bit got;
        per_v = per;
        wave_on = 1'b1;
        repeat (3 * per) @(negedge clk);
        q.delete();
        gate_cycles = gate;
        continuous = 1'b0;
        pulse_start();
        chk({name, " busy_rise"}, busy, 1);
        gate_cycles = $urandom_range(1, 5);
        wait_res(1200, r, got);
        if (got) begin
            chk({name, " ref_count"}, r.r, er);
            chk({name, " sig_count"}, r.s, es);
            chk({name, " timeout"}, r.t, 0);
            chk({name, " overflow"}, r.o, eo);
            chk({name, " busy_after"}, busy, 0);
        end
        wave_on = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        vec_t vt[8];
        res_t r1, r2, r3;
        bit g1, g2, g3;
        int er, es;
        bit eo;
        int t0;

        vt[0] = '{10, 95, 100, 10, 1'b0};
        vt[1] = '{4, 8, 8, 2, 1'b0};
        vt[2] = '{7, 50, 56, 8, 1'b0};
        vt[3] = '{3, 0, 3, 1, 1'b0};
        vt[4] = '{5, 300, 255, 51, 1'b1};
        vt[5] = '{9, 9, 9, 1, 1'b0};
        vt[6] = '{2, 254, 254, 127, 1'b0};
        vt[7] = '{2, 255, 255, 128, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset result_valid", result_valid, 0);
        chk("reset ref_count", ref_count, 0);
        chk("reset sig_count", sig_count, 0);
        chk("reset flags", {timeout, overflow}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_meas($sformatf("vec%0d", i), vt[i].per, vt[i].gate,
                     vt[i].ref_e, vt[i].sig_e, vt[i].ovf_e);

        for (int i = 0; i < 16; i++) begin
            int p, g;
            p = $urandom_range(2, 12);
            g = $urandom_range(0, 220);
            model(p, g, er, es, eo);
            run_meas($sformatf("rnd%0d_p%0d_g%0d", i, p, g), p, g, er, es, eo);
        end

        // continuous: back-to-back results with no dead time
        per_v = 7;
        wave_on = 1'b1;
        repeat (20) @(negedge clk);
        q.delete();
        gate_cycles = 50;
        continuous = 1'b1;
        pulse_start();
        wait_res(1200, r1, g1);
        wait_res(1200, r2, g2);
        @(negedge clk) continuous = 1'b0;
        wait_res(1200, r3, g3);
        if (g1 && g2 && g3) begin
            chk("cont r1 ref", r1.r, 56);
            chk("cont r1 sig", r1.s, 8);
            chk("cont r2 ref", r2.r, 56);
            chk("cont r2 sig", r2.s, 8);
            chk("cont r3 ref", r3.r, 56);
            chk("cont r3 sig", r3.s, 8);
            chk("cont spacing12", r2.c - r1.c, 56);
            chk("cont spacing23", r3.c - r2.c, 56);
        end
        repeat (2) @(negedge clk);
        chk("cont idle after", busy, 0);
        repeat (100) @(negedge clk);
        chk("cont no extra result", q.size(), 0);
        wave_on = 1'b0;
        repeat (5) @(negedge clk);

        // timeout with wave stuck low
        q.delete();
        @(negedge clk);
        start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk) start = 1'b0;
        wait_res(1200, r1, g1);
        if (g1) begin
            chk("tmo latency", r1.c - t0, TMO);
            chk("tmo flag", r1.t, 1);
            chk("tmo ref", r1.r, 0);
            chk("tmo sig", r1.s, 0);
            chk("tmo overflow", r1.o, 0);
            chk("tmo busy after", busy, 0);
        end

        // abort mid-measurement, outputs hold, then a clean measurement
        run_meas("pre_abort", 6, 20, 24, 4, 1'b0);
        per_v = 4;
        wave_on = 1'b1;
        repeat (12) @(negedge clk);
        q.delete();
        gate_cycles = 100;
        pulse_start();
        repeat (20) @(negedge clk);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk("abort busy", busy, 0);
        repeat (300) @(negedge clk);
        chk("abort no result", q.size(), 0);
        chk("abort hold ref", ref_count, 24);
        chk("abort hold sig", sig_count, 4);
        wave_on = 1'b0;
        repeat (4) @(negedge clk);
        run_meas("post_abort", 4, 8, 8, 2, 1'b0);

        // start together with abort in IDLE
        q.delete();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort busy", busy, 0);
        repeat (20) @(negedge clk);
        chk("start_abort no result", q.size(), 0);

        // async reset mid-measurement
        per_v = 10;
        wave_on = 1'b1;
        repeat (30) @(negedge clk);
        q.delete();
        gate_cycles = 95;
        pulse_start();
        repeat (40) @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        start = 1'b1;
        #1;
        chk("rst busy", busy, 0);
        chk("rst ref_count", ref_count, 0);
        chk("rst sig_count", sig_count, 0);
        chk("rst valid", result_valid, 0);
        repeat (5) @(negedge clk);
        chk("rst start ignored", busy, 0);
        start = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst released idle", busy, 0);
        chk("rst no result", q.size(), 0);
        wave_on = 1'b0;
        repeat (4) @(negedge clk);
        run_meas("post_rst", 10, 95, 100, 10, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
